// File: rtl/transport_pkg.sv
// Shared transport-layer definitions: packet headers, session word qualifiers and framer states.
// The receive side uses the same package.
package transport_pkg;

    localparam logic [7:0] HDR_CONTROL = 8'h40;
    localparam logic [7:0] HDR_AUDIO   = 8'h80;

    localparam logic [1:0] SES_NONE  = 2'b00;
    localparam logic [1:0] SES_CTRL  = 2'b01;
    localparam logic [1:0] SES_AUDIO = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_PAYLOAD = 2'd2,
        S_PAD     = 2'd3
    } tx_state_t;

    typedef enum logic {
        PKT_CONTROL = 1'b0,
        PKT_AUDIO   = 1'b1
    } pkt_type_t;

    function automatic logic [7:0] header_for(input pkt_type_t t);
        return (t == PKT_AUDIO) ? HDR_AUDIO : HDR_CONTROL;
    endfunction

endpackage

// File: rtl/transport_send_fifo.sv
// Audio sample FIFO for the transmit framer: first-word fall-through head plus a peek at the
// following word, so the framer can register the next sample's high byte on the same edge it pops.
module tx_audio_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [WIDTH-1:0]         o_head_next,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_pop;
    logic             w_push;

    // A pop in the same cycle frees the slot, so a push onto a full FIFO is still taken.
    assign w_pop  = i_pop & (r_count != '0);
    assign w_push = i_push & ((r_count != FULL_CNT) | w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head      = r_mem[r_rd_ptr];
    assign o_head_next = r_mem[r_rd_ptr + PTR_W'(1)];
    assign o_full      = (r_count == FULL_CNT);
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;

endmodule

// File: rtl/transport_send.sv
// Transport transmit framer: buffers control words and audio samples from the session layer and
// streams fixed-size byte packets to the network layer, one byte per sendSignal/netReady handshake.
//
//  state     | meaning
//  S_IDLE    | no packet on the wire; picks control first, else audio once a full packet is buffered
//  S_HEADER  | header byte presented
//  S_PAYLOAD | control word bytes, or audio samples hi/lo (pop on lo)
//  S_PAD     | zero fill up to PACKET_BYTES
module transport_send
    import transport_pkg::*;
#(
    parameter int PACKET_BYTES = 16,
    parameter int AUDIO_WORDS  = 7,
    parameter int AUDIO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  fromSession,
    input  logic [15:0] sessionData,
    output logic        busy,
    input  logic        netReady,
    output logic        sendSignal,
    output logic [7:0]  packetOut,
    output logic        dropped
);

    localparam int BCNT_W = $clog2(PACKET_BYTES);
    localparam int CNT_W  = $clog2(AUDIO_DEPTH) + 1;
    localparam logic [BCNT_W-1:0] CTRL_LAST  = BCNT_W'(2);
    localparam logic [BCNT_W-1:0] AUDIO_LAST = BCNT_W'(2 * AUDIO_WORDS);
    localparam logic [BCNT_W-1:0] PKT_LAST   = BCNT_W'(PACKET_BYTES - 1);
    localparam logic [CNT_W-1:0]  AUDIO_MIN  = CNT_W'(AUDIO_WORDS);

    tx_state_t         r_state;
    pkt_type_t         r_type;
    logic [BCNT_W-1:0] r_bcnt;
    logic              r_send;
    logic [7:0]        r_byte;
    logic              r_dropped;
    logic              r_ctrl_pending;
    logic [15:0]       r_ctrl_word;

    logic              w_xfer;
    logic              w_ctrl_offer;
    logic              w_ctrl_clear;
    logic              w_ctrl_accept;
    logic              w_audio_offer;
    logic              w_audio_accept;
    logic              w_pop;
    logic [15:0]       w_head;
    logic [15:0]       w_head_next;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [BCNT_W-1:0] w_bcnt_nxt;
    logic [BCNT_W-1:0] w_last_payload;
    logic [7:0]        w_next_byte;

    assign w_xfer         = r_send & netReady;
    assign w_last_payload = (r_type == PKT_CONTROL) ? CTRL_LAST : AUDIO_LAST;

    assign w_ctrl_clear  = w_xfer && (r_state == S_PAYLOAD) && (r_type == PKT_CONTROL)
                           && (r_bcnt == CTRL_LAST);
    assign w_ctrl_offer  = (fromSession == SES_CTRL);
    assign w_ctrl_accept = w_ctrl_offer & (~r_ctrl_pending | w_ctrl_clear);

    // Payload low bytes sit at even byte indices; the sample leaves the FIFO as its low byte goes out.
    assign w_pop = w_xfer && (r_state == S_PAYLOAD) && (r_type == PKT_AUDIO)
                   && !r_bcnt[0] && !w_fifo_empty;

    assign w_audio_offer  = (fromSession == SES_AUDIO);
    assign w_audio_accept = w_audio_offer & (~w_fifo_full | w_pop);

    tx_audio_fifo #(
        .WIDTH (16),
        .DEPTH (AUDIO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_audio_accept),
        .i_data      (sessionData),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_head_next (w_head_next),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl_pending <= 1'b0;
            r_ctrl_word    <= '0;
            r_dropped      <= 1'b0;
        end else begin
            if (w_ctrl_accept) begin
                r_ctrl_pending <= 1'b1;
                r_ctrl_word    <= sessionData;
            end else if (w_ctrl_clear) begin
                r_ctrl_pending <= 1'b0;
            end
            r_dropped <= (w_ctrl_offer & ~w_ctrl_accept) | (w_audio_offer & ~w_audio_accept);
        end
    end

    // Byte to present after the current one transfers; outputs are registered one byte ahead.
    always_comb begin
        w_bcnt_nxt  = r_bcnt + BCNT_W'(1);
        w_next_byte = 8'h00;
        if (r_type == PKT_CONTROL) begin
            if (w_bcnt_nxt == BCNT_W'(1))
                w_next_byte = r_ctrl_word[15:8];
            else if (w_bcnt_nxt == CTRL_LAST)
                w_next_byte = r_ctrl_word[7:0];
        end else if (w_bcnt_nxt <= AUDIO_LAST) begin
            if (!w_bcnt_nxt[0])
                w_next_byte = w_head[7:0];
            else if (r_bcnt == '0)
                w_next_byte = w_head[15:8];
            else
                w_next_byte = w_head_next[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_type  <= PKT_CONTROL;
            r_bcnt  <= '0;
            r_send  <= 1'b0;
            r_byte  <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_send <= 1'b0;
                    r_byte <= 8'h00;
                    r_bcnt <= '0;
                    if (r_ctrl_pending) begin
                        r_type  <= PKT_CONTROL;
                        r_state <= S_HEADER;
                        r_send  <= 1'b1;
                        r_byte  <= header_for(PKT_CONTROL);
                    end else if (w_fifo_count >= AUDIO_MIN) begin
                        r_type  <= PKT_AUDIO;
                        r_state <= S_HEADER;
                        r_send  <= 1'b1;
                        r_byte  <= header_for(PKT_AUDIO);
                    end
                end
                S_HEADER, S_PAYLOAD, S_PAD: begin
                    if (w_xfer) begin
                        r_bcnt <= w_bcnt_nxt;
                        r_byte <= w_next_byte;
                        if (r_bcnt == PKT_LAST) begin
                            r_state <= S_IDLE;
                            r_send  <= 1'b0;
                            r_byte  <= 8'h00;
                        end else if (r_state == S_HEADER) begin
                            r_state <= S_PAYLOAD;
                        end else if ((r_state == S_PAYLOAD) && (r_bcnt == w_last_payload)) begin
                            r_state <= S_PAD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = r_ctrl_pending | w_fifo_full;
    assign sendSignal = r_send;
    assign packetOut  = r_byte;
    assign dropped    = r_dropped;

endmodule

// File: tb/tb_transport_send.sv
// Directed bench for transport_send: expected packet bytes are queued as stimulus is driven and
// compared against bytes captured on each sendSignal/netReady handshake.
module tb_transport_send;
    import transport_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  fromSession;
    logic [15:0] sessionData;
    logic        busy;
    logic        netReady;
    logic        sendSignal;
    logic [7:0]  packetOut;
    logic        dropped;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q [$];
    logic [7:0] rx_q  [$];
    int         len_q [$];
    int         streak    = 0;
    int         stab_err  = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    always #5 clk = ~clk;

    transport_send #(
        .PACKET_BYTES (16),
        .AUDIO_WORDS  (7),
        .AUDIO_DEPTH  (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fromSession (fromSession),
        .sessionData (sessionData),
        .busy        (busy),
        .netReady    (netReady),
        .sendSignal  (sendSignal),
        .packetOut   (packetOut),
        .dropped     (dropped)
    );

    // Capture: inputs change on negedge, so at negedge+1 the values here are those the next posedge sees.
    always @(negedge clk) begin
        #1;
        if (prev_hold && !(sendSignal && (packetOut == prev_byte))) stab_err++;
        prev_hold = sendSignal && !netReady;
        prev_byte = packetOut;
        if (sendSignal) begin
            streak++;
            if (netReady) rx_q.push_back(packetOut);
        end else if (streak != 0) begin
            len_q.push_back(streak);
            streak = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [1:0] code, input logic [15:0] d);
        @(negedge clk);
        fromSession = code;
        sessionData = d;
    endtask

    task automatic idle_in();
        @(negedge clk);
        fromSession = SES_NONE;
        sessionData = 16'h0000;
    endtask

    task automatic exp_ctrl(input logic [15:0] w);
        exp_q.push_back(HDR_CONTROL);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
        repeat (13) exp_q.push_back(8'h00);
    endtask

    task automatic exp_audio(input logic [15:0] base, input logic [15:0] step);
        logic [15:0] w;
        exp_q.push_back(HDR_AUDIO);
        for (int i = 0; i < 7; i++) begin
            w = base + 16'(i) * step;
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
        exp_q.push_back(8'h00);
    endtask

    task automatic drain(input int n, input string tag, input bit toggle);
        int budget;
        for (int i = 0; i < n; i++) begin
            budget = 0;
            while (rx_q.size() == 0 && budget < 400) begin
                @(negedge clk);
                if (toggle) netReady = ~netReady;
                #2;
                budget++;
            end
            if (rx_q.size() == 0) begin
                chk({tag, "_timeout"}, 32'(rx_q.size()), 32'd1);
                exp_q.delete();
                return;
            end
            chk(tag, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic chk_len(input string tag);
        int l;
        l = (len_q.size() > 0) ? len_q.pop_front() : -1;
        chk(tag, 32'(l), 32'd16);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int budget;
        reset       = 1'b1;
        netReady    = 1'b0;
        fromSession = SES_NONE;
        sessionData = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_send",    32'(sendSignal), 32'd0);
        chk("rst_pkt",     32'(packetOut),  32'd0);
        chk("rst_dropped", 32'(dropped),    32'd0);
        chk("rst_busy",    32'(busy),       32'd0);
        reset    = 1'b0;
        netReady = 1'b1;
        repeat (2) @(negedge clk);

        // Control word, latency to header and packet length
        len_q.delete();
        offer(SES_CTRL, 16'hBEEF);
        idle_in();
        chk("t1_busy_pending", 32'(busy),       32'd1);
        chk("t1_send_n1",      32'(sendSignal), 32'd0);
        @(negedge clk);
        chk("t1_send_n2",      32'(sendSignal), 32'd1);
        chk("t1_hdr_n2",       32'(packetOut),  32'(HDR_CONTROL));
        exp_ctrl(16'hBEEF);
        drain(16, "t1_byte", 1'b0);
        repeat (3) @(negedge clk);
        chk_len("t1_send_len");
        chk("t1_busy_after", 32'(busy), 32'd0);

        // Audio: six samples never start a packet, the seventh does
        for (int k = 1; k <= 6; k++) offer(SES_AUDIO, 16'(k * 16'h0101));
        idle_in();
        repeat (10) @(negedge clk);
        chk("t2_six_no_send", 32'(sendSignal),         32'd0);
        chk("t2_six_no_rx",   32'(rx_q.size()),        32'd0);
        chk("t2_six_count",   32'(dut.u_fifo.o_count), 32'd6);
        exp_audio(16'h0101, 16'h0101);
        offer(SES_AUDIO, 16'h0707);
        idle_in();
        drain(16, "t2_byte", 1'b0);
        repeat (3) @(negedge clk);
        chk("t2_fifo_empty", 32'(dut.u_fifo.o_count), 32'd0);
        chk("t2_idle_send",  32'(sendSignal),         32'd0);

        // Back-pressure: netReady toggles, bytes must hold while stalled
        stab_err = 0;
        netReady = 1'b0;
        offer(SES_CTRL, 16'hBEEF);
        idle_in();
        exp_ctrl(16'hBEEF);
        drain(16, "t3_byte", 1'b1);
        netReady = 1'b1;
        repeat (3) @(negedge clk);
        chk("t3_stable", 32'(stab_err), 32'd0);

        // Drops: control while pending, audio on a full FIFO
        offer(SES_CTRL, 16'hA5A5);
        offer(SES_CTRL, 16'h5A5A);
        chk("t4_first_no_drop", 32'(dropped), 32'd0);
        idle_in();
        chk("t4_ctrl_drop", 32'(dropped), 32'd1);
        @(negedge clk);
        chk("t4_drop_pulse", 32'(dropped), 32'd0);
        exp_ctrl(16'hA5A5);
        drain(16, "t4_ctrl_byte", 1'b0);
        repeat (3) @(negedge clk);
        netReady = 1'b0;
        for (int i = 0; i < 16; i++) offer(SES_AUDIO, 16'h1000 + 16'(i));
        offer(SES_AUDIO, 16'hDEAD);
        chk("t4_16th_no_drop", 32'(dropped), 32'd0);
        idle_in();
        chk("t4_full_drop",  32'(dropped),             32'd1);
        chk("t4_full_busy",  32'(busy),                32'd1);
        chk("t4_full_count", 32'(dut.u_fifo.o_count),  32'd16);
        netReady = 1'b1;
        exp_audio(16'h1000, 16'h0001);
        exp_audio(16'h1007, 16'h0001);
        drain(32, "t4_audio_byte", 1'b0);
        do_reset();
        chk("t4_reset_count", 32'(dut.u_fifo.o_count), 32'd0);

        // Control arriving during an audio header waits for the audio packet
        len_q.delete();
        for (int i = 0; i < 7; i++) offer(SES_AUDIO, 16'hA001 + 16'(i));
        idle_in();
        budget = 0;
        while (!sendSignal && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("t5_audio_start", 32'(sendSignal), 32'd1);
        chk("t5_audio_hdr",   32'(packetOut),  32'(HDR_AUDIO));
        fromSession = SES_CTRL;
        sessionData = 16'hC0DE;
        idle_in();
        chk("t5_ctrl_no_drop", 32'(dropped), 32'd0);
        exp_audio(16'hA001, 16'h0001);
        exp_ctrl(16'hC0DE);
        drain(32, "t5_byte", 1'b0);
        repeat (3) @(negedge clk);
        chk("t5_two_packets", 32'(len_q.size()), 32'd2);
        chk_len("t5_audio_len");
        chk_len("t5_ctrl_len");

        // Reset during an audio packet truncates it
        for (int k = 1; k <= 7; k++) offer(SES_AUDIO, 16'(k * 16'h0101));
        idle_in();
        exp_q.push_back(HDR_AUDIO);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h02);
        budget = 0;
        while (rx_q.size() < 5 && budget < 60) begin
            @(negedge clk);
            #2;
            budget++;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("t6_send_after_rst", 32'(sendSignal),        32'd0);
        chk("t6_busy_after_rst", 32'(busy),              32'd0);
        chk("t6_count_after_rst", 32'(dut.u_fifo.o_count), 32'd0);
        reset = 1'b0;
        drain(5, "t6_partial_byte", 1'b0);
        repeat (20) @(negedge clk);
        chk("t6_no_more_bytes", 32'(rx_q.size()), 32'd0);
        chk("t6_quiet_send",    32'(sendSignal),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
